mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage. It sits beside the ALU on the same operand bus and takes the MULT/MULTU/DIV/DIVU/MTHI/MTLO work that the single-cycle ALU does not cover. Results go into architectural HI/LO registers, which the writeback path reads for MFHI/MFLO. A start/busy/done handshake lets the pipeline stall while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  sole clock; one clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request strobe; sampled on a rising edge only while `busy`=0.
- `op`  in  3  operation code (see Operation).
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle completion pulse.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `div_by_zero`  out  1  valid only together with `done`.

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are reserved: they are ignored, with no state change and no `done`.
- FSM states: IDLE, RUN, FIX, DONE.
- A start accepted with MULT/MULTU/DIV/DIVU moves IDLE to RUN. RUN lasts WIDTH cycles, one bit per cycle, and then moves to FIX. FIX applies sign correction and writes HI/LO, then moves to DONE. DONE moves back to IDLE.
- A start accepted with MTHI/MTLO writes HI or LO from `a` at the accept edge and moves IDLE to DONE. The other register is unchanged.
- MULT/MULTU produce a 2·WIDTH-bit product: HI gets the upper half, LO the lower half.
  - Signed ops take magnitudes first, run unsigned shift-add, and negate the product in FIX if the operand signs differ.
- DIV/DIVU use restoring division on magnitudes: LO gets the quotient, HI the remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- Divide by zero (`b`=0): LO = all ones, HI = `a`, and `div_by_zero`=1 during `done`. The op still takes the full latency.
- Operands are latched at accept. Changes to `a`, `b` or `op` after that have no effect.
- `start` while `busy`=1, or during DONE, is ignored. It is not queued.
- Reset mid-operation aborts immediately. The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, FSM in IDLE.
- Multiply/divide accepted at edge N:
  - `busy`=1 for cycles N+1 … N+WIDTH+1 (RUN plus FIX).
  - HI/LO update at edge N+WIDTH+1.
  - `done`=1 in cycle N+WIDTH+2 with `busy`=0.
  - Total latency is WIDTH+2 cycles, i.e. 34 cycles for WIDTH=32.
- MT ops accepted at edge N: `hi`/`lo` update at N, `done`=1 in cycle N+1, `busy` never asserts.
- A new start is accepted at the earliest in the cycle after `done`.
- `hi`/`lo` hold their old values throughout RUN and change only at the FIX edge.

## Configuration
- `MDU_DIV_EN` defined: divider datapath is built, and DIV/DIVU behave as specified above.
- `MDU_DIV_EN` undefined: no divider logic is built.
  - DIV/DIVU are accepted as single-cycle no-ops: HI/LO are unchanged, `done` pulses the next cycle, `div_by_zero` stays 0.
  - This keeps the pipeline from hanging.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op_e` enum (3-bit codes above);
  - the `mdu_state_e` FSM enum;
  - the `MDU_DEFAULT_WIDTH` constant.
- `mult_div_unit` holds the FSM, operand latches, sign handling and the HI/LO registers.
- One sub-module, `mdu_iter_core`, holds the shared 2·WIDTH accumulator and iteration counter.
  - It runs one shift-add or shift-subtract step per cycle, selected by a mode bit.
  - The divider step is guarded by `MDU_DIV_EN`.

## Test plan
- MULT a=12, b=−34 → after 34 cycles `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFE68; `busy` was high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- DIVU a=1234, b=0 → lo=0xFFFFFFFF, hi=1234, `div_by_zero`=1 for exactly the `done` cycle.
- MTHI 0x12345678 pulsed during a running MULT → ignored. The same MTHI issued after `done` → hi=0x12345678 next edge, lo unchanged, `done` one cycle later.
- `rst_n` low at RUN iteration 10 → `busy`, `done`, `hi`, `lo` all 0 immediately; after release, a fresh MULT 3×5 gives lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divider datapath is only built when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam int MDU_DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Shared 2*WIDTH accumulator: one unsigned shift-add (multiply) or restoring
// shift-subtract (divide, only with MDU_DIV_EN) step per enabled cycle.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
`ifdef MDU_DIV_EN
  input  logic               div_mode,
`endif
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   opb_q;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     add_sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]     rem_wide;
  logic [WIDTH+1:0]   diff;
`endif

  assign last = (count == CW'(WIDTH - 1));

  // Multiply: low half holds the multiplier, partial product grows in the high half.
  // Divide: low half holds the dividend/quotient, high half the partial remainder.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
    acc_next = {add_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    rem_wide = acc[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, rem_wide} - {2'b00, opb_q};
    if (div_mode) begin
      if (diff[WIDTH+1]) begin
        acc_next = {rem_wide[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opb_q <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, opa};
      opb_q <= opb;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: FSM, operand sign handling and HI/LO registers.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are one-cycle no-ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  mdu_state_e         state, state_next;
  mdu_op_e            op_code;
  logic               accept, is_mul, signed_op;
  logic               a_neg, b_neg, neg_prod;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               core_load, core_last;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef MDU_DIV_EN
  logic               is_div, div_q, neg_rem, dbz_q;
  logic [WIDTH-1:0]   a_raw;
`endif

  assign op_code   = mdu_op_e'(op);
  assign accept    = start && (state == ST_IDLE);
  assign is_mul    = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;
  assign busy      = (state == ST_RUN) || (state == ST_FIX);
  assign done      = (state == ST_DONE);

`ifdef MDU_DIV_EN
  assign is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign core_load = accept && (is_mul || is_div);
`else
  assign core_load = accept && is_mul;
`endif

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (state == ST_RUN),
`ifdef MDU_DIV_EN
    .div_mode (div_q),
`endif
    .opa      (mag_a),
    .opb      (mag_b),
    .acc      (acc),
    .last     (core_last)
  );

  // Sign information captured at accept so later operand changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_prod <= 1'b0;
`ifdef MDU_DIV_EN
      div_q    <= 1'b0;
      neg_rem  <= 1'b0;
      dbz_q    <= 1'b0;
      a_raw    <= '0;
`endif
    end else if (core_load) begin
      neg_prod <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
      div_q    <= is_div;
      neg_rem  <= a_neg;
      dbz_q    <= is_div && (b == '0);
      a_raw    <= a;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op_code)
            OP_MULT, OP_MULTU: state_next = ST_RUN;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU:   state_next = ST_RUN;
`else
            OP_DIV, OP_DIVU:   state_next = ST_DONE;
`endif
            OP_MTHI, OP_MTLO:  state_next = ST_DONE;
            default:           state_next = ST_IDLE;
          endcase
        end
      end
      ST_RUN:  if (core_last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Magnitude result from the core, sign-corrected; divide by zero overrides both halves.
  always_comb begin
    prod   = neg_prod ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (div_q) begin
      res_lo = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (dbz_q) begin
        res_lo = '1;
        res_hi = a_raw;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept && (op_code == OP_MTHI)) begin
      hi <= a;
    end else if (accept && (op_code == OP_MTLO)) begin
      lo <= a;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_by_zero <= 1'b0;
    else        div_by_zero <= (state == ST_FIX) && dbz_q;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO values.
  function automatic void refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] eh, output logic [31:0] el,
                                   output logic edbz, output int elat, output int ebusy);
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    eh = hi_m;
    el = lo_m;
    edbz = 1'b0;
    elat = 1;
    ebusy = 0;
    q = 0;
    r = 0;
    case (o)
      3'd0: begin
        p = sx * sy;
        eh = p[63:32];
        el = p[31:0];
        elat = W + 2;
        ebusy = W + 1;
      end
      3'd1: begin
        up = {32'b0, x} * {32'b0, y};
        eh = up[63:32];
        el = up[31:0];
        elat = W + 2;
        ebusy = W + 1;
      end
      3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
        elat = W + 2;
        ebusy = W + 1;
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
          edbz = 1'b1;
        end else if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = x / y;
          eh = x % y;
        end
`endif
      end
      3'd4: eh = x;
      3'd5: el = x;
      default: elat = 0;
    endcase
  endfunction

  // Issues one op; poke_at > 0 re-asserts start (MTHI) on that cycle after accept.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int poke_at);
    logic [31:0] eh, el;
    logic        edbz;
    int          elat, ebusy, lat, busy_cnt;
    bit          hold_ok;
    refModel(o, x, y, eh, el, edbz, elat, ebusy);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= W + 6 && lat == 0; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      if (k == poke_at) begin
        op = 3'd4;
        a = 32'hDEAD_BEEF;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        checkOutput("hi", hi, eh);
        checkOutput("lo", lo, el);
        checkOutput("div_by_zero", div_by_zero, edbz);
      end else if (hi !== hi_m || lo !== lo_m || div_by_zero !== 1'b0) begin
        hold_ok = 1'b0;
      end
    end
    hi_m = eh;
    lo_m = el;
    checkOutput("latency", lat, elat);
    checkOutput("busy_cycles", busy_cnt, ebusy);
    checkOutput("hold_while_busy", hold_ok, 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_single", done, 0);
    checkOutput("dbz_single", div_by_zero, 0);
    checkOutput("hi_after", hi, hi_m);
    checkOutput("lo_after", lo, lo_m);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'd0, 32'd12, 32'hFFFF_FFDE, 0);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd3, 32'd1234, 32'd0, 0);
    applyStimulus(3'd2, 32'hFFFF_FFFB, 32'd0, 0);
    applyStimulus(3'd0, 32'd7, 32'd9, 5);
    applyStimulus(3'd4, 32'h1234_5678, 32'd0, 1);
    applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, 1);
    applyStimulus(3'd6, 32'h1111_1111, 32'd3, 0);
    applyStimulus(3'd7, 32'h2222_2222, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      applyStimulus(ro, pickOperand(), pickOperand(), (ro < 3'd6) ? $urandom_range(0, 3) : 0);
    end

    applyStimulus(3'd4, 32'hA5A5_A5A5, 32'd0, 0);
    applyStimulus(3'd5, 32'h5A5A_5A5A, 32'd0, 0);
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    a = 32'd100;
    b = 32'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'd0, 32'd3, 32'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
